// File: rtl/basket_update_sequencer_if.sv
// basket_update_sequencer_if: request, read-port and status bundle for the basket sequencer.
interface basket_update_sequencer_if;
  logic       Add_Req;
  logic [3:0] Add_ProductID;
  logic [3:0] Add_Quantity;
  logic       Remove_Req;
  logic [3:0] Remove_Index;
  logic       Clear_Req;
  logic [3:0] Rd_Index;
  logic [3:0] Rd_ProductID;
  logic [3:0] Rd_Quantity;
  logic [3:0] BasketProductNum;
  logic       Busy;
  logic       Done;
  logic       Err_Full;
  logic       Err_Index;
  logic       Req_Dropped;
  logic [7:0] TotalItems;
  modport master (
    output Add_Req, Add_ProductID, Add_Quantity, Remove_Req, Remove_Index, Clear_Req, Rd_Index,
    input  Rd_ProductID, Rd_Quantity, BasketProductNum, Busy, Done, Err_Full, Err_Index,
           Req_Dropped, TotalItems
  );
  modport slave (
    input  Add_Req, Add_ProductID, Add_Quantity, Remove_Req, Remove_Index, Clear_Req, Rd_Index,
    output Rd_ProductID, Rd_Quantity, BasketProductNum, Busy, Done, Err_Full, Err_Index,
           Req_Dropped, TotalItems
  );
endinterface

// File: rtl/basket_update_sequencer.sv
// basket_update_sequencer: basket slot storage with add/remove/clear sequencing and a read port.
// Define BASKET_TOTAL_ITEMS_EN to build the TotalItems running-quantity register.
module basket_update_sequencer #(
  parameter int NUM_SLOTS = 8,
  parameter int MAX_QTY   = 15
) (
  input logic CLOCK_50,
  input logic RESET,
  basket_update_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, ALLOC, COMPACT} state_t;
  localparam logic [3:0] NS = 4'(NUM_SLOTS);
  localparam logic [4:0] MQ = 5'(MAX_QTY);
  state_t state_q, state_n;
  logic [3:0] id_q [NUM_SLOTS];
  logic [3:0] qty_q [NUM_SLOTS];
  logic [3:0] id_n [NUM_SLOTS];
  logic [3:0] qty_n [NUM_SLOTS];
  logic [3:0] sh_id [NUM_SLOTS];
  logic [3:0] sh_qty [NUM_SLOTS];
  logic [3:0] cnt_q, cnt_n, idx_q, idx_n, aid_q, aid_n, aqty_q, aqty_n;
  logic [3:0] cur_id, cur_qty, sat_qty, new_qty, rd_id, rd_qty;
  logic [4:0] sum;
  logic busy_q, done_q, done_n, efull_q, efull_n, eidx_q, eidx_n, drop_q, drop_n;
  logic hit, room, any_req;
  assign any_req = bus.Add_Req | bus.Remove_Req | bus.Clear_Req;
  assign hit     = idx_q != cnt_q && cur_id == aid_q;
  assign room    = cnt_q < NS;
  assign sum     = {1'b0, cur_qty} + {1'b0, aqty_q};
  assign sat_qty = sum > MQ ? MQ[3:0] : sum[3:0];
  assign new_qty = {1'b0, aqty_q} > MQ ? MQ[3:0] : aqty_q;
  // Slot under the search/compact pointer, read-port mux and the one-slot-down shifted view
  always_comb begin
    cur_id  = '0;
    cur_qty = '0;
    rd_id   = '0;
    rd_qty  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (4'(i) == idx_q) begin
        cur_id  = id_q[i];
        cur_qty = qty_q[i];
      end
      if (4'(i) == bus.Rd_Index && 4'(i) < cnt_q) begin
        rd_id  = id_q[i];
        rd_qty = qty_q[i];
      end
    end
    for (int i = 0; i < NUM_SLOTS - 1; i++) begin
      sh_id[i]  = id_q[i+1];
      sh_qty[i] = qty_q[i+1];
    end
    sh_id[NUM_SLOTS-1]  = '0;
    sh_qty[NUM_SLOTS-1] = '0;
  end
  always_comb begin
    state_n = state_q;
    id_n    = id_q;
    qty_n   = qty_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    aid_n   = aid_q;
    aqty_n  = aqty_q;
    done_n  = 1'b0;
    efull_n = 1'b0;
    eidx_n  = 1'b0;
    drop_n  = 1'b0;
    case (state_q)
      IDLE: begin
        drop_n = (bus.Clear_Req & (bus.Remove_Req | bus.Add_Req)) | (bus.Remove_Req & bus.Add_Req);
        if (bus.Clear_Req) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            id_n[i]  = '0;
            qty_n[i] = '0;
          end
          cnt_n  = '0;
          done_n = 1'b1;
        end else if (bus.Remove_Req) begin
          eidx_n  = bus.Remove_Index >= cnt_q;
          state_n = bus.Remove_Index >= cnt_q ? IDLE : COMPACT;
          idx_n   = bus.Remove_Index;
        end else if (bus.Add_Req) begin
          aid_n   = bus.Add_ProductID;
          aqty_n  = bus.Add_Quantity;
          done_n  = bus.Add_Quantity == '0;
          state_n = bus.Add_Quantity == '0 ? IDLE : SEARCH;
          idx_n   = '0;
        end
      end
      SEARCH: begin
        drop_n  = any_req;
        state_n = idx_q == cnt_q ? ALLOC : hit ? IDLE : SEARCH;
        done_n  = hit;
        idx_n   = idx_q + 4'd1;
        for (int i = 0; i < NUM_SLOTS; i++)
          if (hit && 4'(i) == idx_q) qty_n[i] = sat_qty;
      end
      ALLOC: begin
        drop_n  = any_req;
        state_n = IDLE;
        done_n  = room;
        efull_n = !room;
        cnt_n   = room ? cnt_q + 4'd1 : cnt_q;
        for (int i = 0; i < NUM_SLOTS; i++)
          if (room && 4'(i) == cnt_q) begin
            id_n[i]  = aid_q;
            qty_n[i] = new_qty;
          end
      end
      default: begin
        // Slots past the last occupied one are zero, so shifting also clears the vacated slot
        drop_n = any_req;
        for (int i = 0; i < NUM_SLOTS; i++)
          if (4'(i) == idx_q) begin
            id_n[i]  = sh_id[i];
            qty_n[i] = sh_qty[i];
          end
        done_n  = idx_q == cnt_q - 4'd1;
        state_n = idx_q == cnt_q - 4'd1 ? IDLE : COMPACT;
        cnt_n   = idx_q == cnt_q - 4'd1 ? cnt_q - 4'd1 : cnt_q;
        idx_n   = idx_q + 4'd1;
      end
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        id_q[i]  <= '0;
        qty_q[i] <= '0;
      end
      cnt_q   <= '0;
      idx_q   <= '0;
      aid_q   <= '0;
      aqty_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      efull_q <= 1'b0;
      eidx_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      id_q    <= id_n;
      qty_q   <= qty_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      aid_q   <= aid_n;
      aqty_q  <= aqty_n;
      busy_q  <= state_n != IDLE;
      done_q  <= done_n;
      efull_q <= efull_n;
      eidx_q  <= eidx_n;
      drop_q  <= drop_n;
    end
  end
  assign bus.Rd_ProductID     = rd_id;
  assign bus.Rd_Quantity      = rd_qty;
  assign bus.BasketProductNum = cnt_q;
  assign bus.Busy             = busy_q;
  assign bus.Done             = done_q;
  assign bus.Err_Full         = efull_q;
  assign bus.Err_Index        = eidx_q;
  assign bus.Req_Dropped      = drop_q;
`ifdef BASKET_TOTAL_ITEMS_EN
  logic [7:0] tot_q, tot_n;
  logic [3:0] rm_qty;
  // Bounded by MAX_QTY per slot, so the add/subtract below never wraps
  always_comb begin
    rm_qty = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (4'(i) == bus.Remove_Index) rm_qty = qty_q[i];
    tot_n = tot_q;
    if (state_q == IDLE && bus.Clear_Req) tot_n = '0;
    else if (state_q == IDLE && bus.Remove_Req && bus.Remove_Index < cnt_q) tot_n = tot_q - 8'(rm_qty);
    else if (state_q == SEARCH && hit) tot_n = tot_q + 8'(sat_qty - cur_qty);
    else if (state_q == ALLOC && room) tot_n = tot_q + 8'(new_qty);
  end
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) tot_q <= '0;
    else tot_q <= tot_n;
  end
  assign bus.TotalItems = tot_q;
`else
  assign bus.TotalItems = '0;
`endif
endmodule

// File: tb/tb_basket_update_sequencer.sv
// tb_basket_update_sequencer: scoreboard bench for basket_update_sequencer.
`timescale 1ns/1ps
module tb_basket_update_sequencer;
  typedef struct {
    logic [3:0] kind;
    int         lat;
  } exp_t;
  logic CLOCK_50 = 1'b0;
  logic RESET = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];
  logic [3:0] m_id [16];
  logic [3:0] m_qty [16];
  int m_cnt = 0;
  int m_tot = 0;
  basket_update_sequencer_if bus();
  basket_update_sequencer dut (.CLOCK_50(CLOCK_50), .RESET(RESET), .bus(bus));
  always #10 CLOCK_50 = ~CLOCK_50;
  function automatic int exp_tot();
`ifdef BASKET_TOTAL_ITEMS_EN
    return m_tot;
`else
    return 0;
`endif
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_id[i] = '0;
      m_qty[i] = '0;
    end
    m_cnt = 0;
    m_tot = 0;
  endtask
  task automatic model_add(input logic [3:0] id, input logic [3:0] q);
    exp_t e;
    int k = -1;
    int s;
    if (q == 0) e = '{4'b1000, 1};
    else begin
      for (int i = 0; i < m_cnt; i++) if (k < 0 && m_id[i] == id) k = i;
      if (k >= 0) begin
        s = int'(m_qty[k]) + int'(q);
        if (s > 15) s = 15;
        m_tot += s - int'(m_qty[k]);
        m_qty[k] = 4'(s);
        e = '{4'b1000, k + 2};
      end else if (m_cnt < 8) begin
        e = '{4'b1000, m_cnt + 3};
        m_id[m_cnt] = id;
        m_qty[m_cnt] = q;
        m_tot += int'(q);
        m_cnt++;
      end else e = '{4'b0100, m_cnt + 3};
    end
    sb.push_back(e);
  endtask
  task automatic model_remove(input int idx);
    exp_t e;
    if (idx >= m_cnt) e = '{4'b0010, 1};
    else begin
      e = '{4'b1000, m_cnt - idx + 1};
      m_tot -= int'(m_qty[idx]);
      for (int j = idx; j < m_cnt - 1; j++) begin
        m_id[j] = m_id[j+1];
        m_qty[j] = m_qty[j+1];
      end
      m_id[m_cnt-1] = '0;
      m_qty[m_cnt-1] = '0;
      m_cnt--;
    end
    sb.push_back(e);
  endtask
  task automatic issue(input logic a, input logic [3:0] id, input logic [3:0] q,
                       input logic r, input logic [3:0] ri, input logic c);
    bus.Add_Req = a;
    bus.Add_ProductID = id;
    bus.Add_Quantity = q;
    bus.Remove_Req = r;
    bus.Remove_Index = ri;
    bus.Clear_Req = c;
    @(posedge CLOCK_50);
    #1;
    bus.Add_Req = 1'b0;
    bus.Remove_Req = 1'b0;
    bus.Clear_Req = 1'b0;
  endtask
  task automatic await_result(input string name, input int c0);
    exp_t e;
    int c = c0;
    logic [3:0] got = {bus.Done, bus.Err_Full, bus.Err_Index, bus.Busy};
    while (got[3:1] == 3'b000 && c < 40) begin
      @(posedge CLOCK_50);
      #1;
      c++;
      got = {bus.Done, bus.Err_Full, bus.Err_Index, bus.Busy};
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s: flags %b at cycle %0d with no expectation queued", name, got, c);
      return;
    end
    e = sb.pop_front();
    if (got !== e.kind || c != e.lat) begin
      n_errors++;
      $display("FAIL %s: done/full/idx/busy=%b at cycle %0d, expected %b at cycle %0d",
               name, got, c, e.kind, e.lat);
    end
  endtask
  task automatic check_basket(input string name);
    n_checks++;
    if (bus.BasketProductNum !== 4'(m_cnt)) begin
      n_errors++;
      $display("FAIL %s count: got %0d expected %0d", name, bus.BasketProductNum, m_cnt);
    end
    n_checks++;
    if (bus.TotalItems !== 8'(exp_tot())) begin
      n_errors++;
      $display("FAIL %s total: got %0d expected %0d", name, bus.TotalItems, exp_tot());
    end
    for (int i = 0; i < 10; i++) begin
      bus.Rd_Index = 4'(i);
      #1;
      n_checks++;
      if ({bus.Rd_ProductID, bus.Rd_Quantity} !== {m_id[i], m_qty[i]}) begin
        n_errors++;
        $display("FAIL %s slot%0d: got {%0d,%0d} expected {%0d,%0d}", name, i,
                 bus.Rd_ProductID, bus.Rd_Quantity, m_id[i], m_qty[i]);
      end
    end
  endtask
  task automatic do_add(input string name, input logic [3:0] id, input logic [3:0] q);
    model_add(id, q);
    issue(1'b1, id, q, 1'b0, 4'd0, 1'b0);
    await_result(name, 1);
  endtask
  task automatic do_remove(input string name, input int idx);
    model_remove(idx);
    issue(1'b0, 4'd0, 4'd0, 1'b1, 4'(idx), 1'b0);
    await_result(name, 1);
  endtask
  task automatic do_clear(input string name);
    model_clear();
    sb.push_back('{4'b1000, 1});
    issue(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    await_result(name, 1);
  endtask
  task automatic check_dropped(input string name);
    n_checks++;
    if (bus.Req_Dropped !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: Req_Dropped=%b expected 1", name, bus.Req_Dropped);
    end
  endtask
  task automatic test_reset();
    bus.Add_Req = 1'b0;
    bus.Remove_Req = 1'b0;
    bus.Clear_Req = 1'b0;
    bus.Add_ProductID = '0;
    bus.Add_Quantity = '0;
    bus.Remove_Index = '0;
    bus.Rd_Index = '0;
    RESET = 1'b1;
    model_clear();
    repeat (2) @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    n_checks++;
    if ({bus.Busy, bus.Done, bus.Err_Full, bus.Err_Index, bus.Req_Dropped} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_status: got %b expected 00000",
               {bus.Busy, bus.Done, bus.Err_Full, bus.Err_Index, bus.Req_Dropped});
    end
    check_basket("reset");
  endtask
  task automatic test_add();
    do_add("add_3_2", 4'd3, 4'd2);
    do_add("add_5_4", 4'd5, 4'd4);
    do_add("add_qty0", 4'd7, 4'd0);
    check_basket("add");
  endtask
  task automatic test_saturate();
    do_add("add_sat", 4'd3, 4'd14);
    check_basket("saturate");
  endtask
  task automatic test_full();
    do_clear("full_clear");
    for (int i = 1; i <= 8; i++) do_add("fill", 4'(i), 4'd1);
    do_add("add_full", 4'd9, 4'd1);
    check_basket("full");
  endtask
  task automatic test_remove();
    do_clear("rm_clear");
    for (int i = 1; i <= 4; i++) do_add("rm_fill", 4'(i), 4'(i));
    do_remove("rm_1", 1);
    check_basket("remove_mid");
    do_remove("rm_bad", 3);
    do_remove("rm_last", 2);
    check_basket("remove_last");
  endtask
  task automatic test_arbitration();
    model_clear();
    sb.push_back('{4'b1000, 1});
    issue(1'b1, 4'd5, 4'd1, 1'b0, 4'd0, 1'b1);
    check_dropped("clear_vs_add");
    await_result("clear_wins", 1);
    check_basket("arb_clear");
    do_add("arb_a", 4'd1, 4'd1);
    do_add("arb_b", 4'd2, 4'd1);
    model_add(4'd2, 4'd1);
    issue(1'b1, 4'd2, 4'd1, 1'b0, 4'd0, 1'b0);
    bus.Add_Req = 1'b1;
    bus.Add_ProductID = 4'd9;
    bus.Add_Quantity = 4'd1;
    @(posedge CLOCK_50);
    #1;
    bus.Add_Req = 1'b0;
    check_dropped("add_while_busy");
    await_result("add_busy_completes", 2);
    check_basket("arb_busy");
  endtask
  task automatic test_back_to_back();
    model_remove(0);
    issue(1'b1, 4'd9, 4'd1, 1'b1, 4'd0, 1'b0);
    check_dropped("remove_vs_add");
    await_result("remove_wins", 1);
    check_basket("b2b");
  endtask
  task automatic test_reset_mid_compact();
    do_add("mid_a", 4'd4, 4'd1);
    do_add("mid_b", 4'd5, 4'd1);
    do_add("mid_c", 4'd6, 4'd1);
    issue(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0);
    @(posedge CLOCK_50);
    #3;
    RESET = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if ({bus.Busy, bus.Done, bus.Err_Full, bus.Err_Index, bus.Req_Dropped} !== 5'b0) begin
      n_errors++;
      $display("FAIL mid_reset_status: got %b expected 00000",
               {bus.Busy, bus.Done, bus.Err_Full, bus.Err_Index, bus.Req_Dropped});
    end
    check_basket("mid_reset");
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    do_add("post_reset_add", 4'd7, 4'd1);
    check_basket("post_reset");
  endtask
  initial begin
    test_reset();
    test_add();
    test_saturate();
    test_full();
    test_remove();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_compact();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
